// File: rtl/aes_word_serializer.sv
// Streams one latched 128-bit AES result block out as NUM_WORDS words, MS word first,
// over valid/ready with zero-bubble back-to-back block acceptance.
module aes_word_serializer #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int CNT_W     = 16,
    localparam int BLK_W    = WORD_W * NUM_WORDS,
    localparam int IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BLK_W-1:0]  in_block,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [CNT_W-1:0]  blk_count
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   block_q, block_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_last;
    logic               xfer;
    logic               accept;

    always_comb begin
        is_last  = (idx_q == LAST_IDX);
        xfer     = (state_q == SEND) && out_ready;
        in_ready = !rst && ((state_q == IDLE) || (out_ready && is_last));
        accept   = in_valid && in_ready;

        state_d  = state_q;
        block_d  = block_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;

        // The register shifts left so the current word always sits at the top;
        // after the final word it drains to zero, leaving out_word quiet in IDLE.
        if (xfer) begin
            block_d = block_q << WORD_W;
            idx_d   = idx_q + IDX_W'(1);
            if (is_last) begin
                cnt_d   = cnt_q + CNT_W'(1);
                idx_d   = '0;
                state_d = IDLE;
            end
        end

        if (accept) begin
            block_d = in_block;
            idx_d   = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            block_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_word  = block_q[BLK_W-1 -: WORD_W];
    assign out_idx   = idx_q;
    assign out_last  = (state_q == SEND) && is_last;
    assign blk_count = cnt_q;

endmodule
